// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses SYNC/CMD/ADDR/DATA/CHK frames from the UART receiver,
// runs the matching 32-bit read/write on the debug bus, releases the CPU from
// halt on RUN, and queues reply bytes to the UART transmitter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | hunting for SYNC_BYTE, everything else discarded
// CMD      | waiting for the command byte
// ADDR0..3 | collecting address bytes, least significant first
// DATA0..3 | collecting write data bytes (write command only)
// CHK      | waiting for the checksum byte, then dispatch
// MEM      | bus request outstanding, waiting for mem_ack
// TX       | next reply byte ready, waiting for the transmitter to be idle
// TXWAIT   | byte handed off, waiting for the transmitter to finish it
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        cpu_halt,
  output logic        rx_overrun
);

  localparam int unsigned   TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] REPLY_ACK = 8'h06;
  localparam logic [7:0] REPLY_NAK = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR0,
    ST_ADDR1,
    ST_ADDR2,
    ST_ADDR3,
    ST_DATA0,
    ST_DATA1,
    ST_DATA2,
    ST_DATA3,
    ST_CHK,
    ST_MEM,
    ST_TX,
    ST_TXWAIT
  } state_t;

  state_t        state;
  logic [7:0]    cmd;
  logic [7:0]    chk_acc;
  logic [TW-1:0] to_cnt;
  logic [39:0]   reply_q;
  logic [2:0]    reply_cnt;
  logic          tx_guard;

  logic          in_frame;
  logic          in_reply;
  logic          to_expire;
  logic [1:0]    byte_sel;
  logic          cmd_known;

  // Frame-phase decode, timeout terminal count and byte lane of the current field
  always_comb begin
    in_frame  = 1'b0;
    in_reply  = 1'b0;
    byte_sel  = 2'd0;
    case (state)
      ST_CMD, ST_CHK:                         in_frame = 1'b1;
      ST_ADDR0, ST_DATA0: begin in_frame = 1'b1; byte_sel = 2'd0; end
      ST_ADDR1, ST_DATA1: begin in_frame = 1'b1; byte_sel = 2'd1; end
      ST_ADDR2, ST_DATA2: begin in_frame = 1'b1; byte_sel = 2'd2; end
      ST_ADDR3, ST_DATA3: begin in_frame = 1'b1; byte_sel = 2'd3; end
      ST_MEM, ST_TX, ST_TXWAIT:               in_reply = 1'b1;
      default: ;
    endcase
    to_expire = (to_cnt == TO_LAST);
    cmd_known = (cmd == CMD_WRITE) || (cmd == CMD_READ) || (cmd == CMD_RUN);
  end

  // Frame parser, bus master and reply sequencer; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd        <= 8'h00;
      chk_acc    <= 8'h00;
      to_cnt     <= '0;
      reply_q    <= 40'h0;
      reply_cnt  <= 3'd0;
      tx_guard   <= 1'b0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      cpu_halt   <= 1'b1;
      rx_overrun <= 1'b0;
    end else begin
      tx_start <= 1'b0;

      // Bytes that arrive while a transaction or reply is in flight are lost.
      if (rx_ready && in_reply)
        rx_overrun <= 1'b1;

      // A byte arriving on the expiry cycle wins over the timeout.
      if (rx_ready || !in_frame || to_expire)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TW'(1);

      if (in_frame && !rx_ready && to_expire) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_ready && (rx_data == SYNC_BYTE))
              state <= ST_CMD;
          end

          ST_CMD: begin
            if (rx_ready) begin
              cmd     <= rx_data;
              chk_acc <= rx_data;
              state   <= ST_ADDR0;
            end
          end

          ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_ADDR3: begin
            if (rx_ready) begin
              mem_addr[{byte_sel, 3'b000} +: 8] <= rx_data;
              chk_acc <= chk_acc ^ rx_data;
              case (state)
                ST_ADDR0: state <= ST_ADDR1;
                ST_ADDR1: state <= ST_ADDR2;
                ST_ADDR2: state <= ST_ADDR3;
                default:  state <= (cmd == CMD_WRITE) ? ST_DATA0 : ST_CHK;
              endcase
            end
          end

          ST_DATA0, ST_DATA1, ST_DATA2, ST_DATA3: begin
            if (rx_ready) begin
              mem_wdata[{byte_sel, 3'b000} +: 8] <= rx_data;
              chk_acc <= chk_acc ^ rx_data;
              case (state)
                ST_DATA0: state <= ST_DATA1;
                ST_DATA1: state <= ST_DATA2;
                ST_DATA2: state <= ST_DATA3;
                default:  state <= ST_CHK;
              endcase
            end
          end

          ST_CHK: begin
            if (rx_ready) begin
              if ((rx_data != chk_acc) || !cmd_known) begin
                reply_q   <= {32'h0, REPLY_NAK};
                reply_cnt <= 3'd1;
                state     <= ST_TX;
              end else if (cmd == CMD_RUN) begin
                cpu_halt  <= 1'b0;
                reply_q   <= {32'h0, REPLY_ACK};
                reply_cnt <= 3'd1;
                state     <= ST_TX;
              end else begin
                mem_req <= 1'b1;
                mem_we  <= (cmd == CMD_WRITE);
                state   <= ST_MEM;
              end
            end
          end

          ST_MEM: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              if (mem_we) begin
                reply_q   <= {32'h0, REPLY_ACK};
                reply_cnt <= 3'd1;
              end else begin
                reply_q   <= {mem_rdata, REPLY_ACK};
                reply_cnt <= 3'd5;
              end
              state <= ST_TX;
            end
          end

          ST_TX: begin
            if (!tx_busy) begin
              tx_data   <= reply_q[7:0];
              tx_start  <= 1'b1;
              reply_q   <= reply_q >> 8;
              reply_cnt <= reply_cnt - 3'd1;
              tx_guard  <= 1'b1;
              state     <= ST_TXWAIT;
            end
          end

          ST_TXWAIT: begin
            // The transmitter may not raise busy until the cycle after start.
            if (tx_guard)
              tx_guard <= 1'b0;
            else if (!tx_busy)
              state <= (reply_cnt != 3'd0) ? ST_TX : ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a behavioural memory responder and
// UART transmitter model; each scenario task checks its own results.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        cpu_halt;
  logic        rx_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder state
  int          ack_delay = 1;
  int          req_len;
  int          req_cnt;
  int          last_req_len;
  int          bus_instab;
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;

  // transmitter model state
  bq_t         tx_log;
  int          busy_left;
  int          start_viol;
  int          data_instab;
  logic [7:0]  held_byte;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(50), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cpu_halt(cpu_halt), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after ack_delay cycles of mem_req, checks stability
  initial begin
    mem_ack = 1'b0;
    req_len = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst || !mem_req) begin
        req_len = 0;
      end else begin
        req_len++;
        if (req_len == 1) begin
          snap_we = mem_we; snap_addr = mem_addr; snap_wdata = mem_wdata;
        end else if (mem_we !== snap_we || mem_addr !== snap_addr || mem_wdata !== snap_wdata) begin
          bus_instab++;
        end
        if (req_len == ack_delay) begin
          mem_ack = 1'b1;
          req_cnt++;
          cap_we = snap_we; cap_addr = snap_addr; cap_wdata = snap_wdata;
          last_req_len = req_len;
        end
      end
    end
  end

  // Transmitter model: busy for 4 cycles per byte, logs bytes and protocol errors
  initial begin
    tx_busy = 1'b0;
    busy_left = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy = 1'b0; busy_left = 0;
      end else if (tx_start) begin
        tx_log.push_back(tx_data);
        if (tx_busy) start_viol++;
        held_byte = tx_data;
        tx_busy = 1'b1;
        busy_left = 4;
      end else if (busy_left > 0) begin
        if (tx_data !== held_byte) data_instab++;
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_seq(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic clear_logs();
    tx_log.delete();
    req_cnt = 0; bus_instab = 0; start_viol = 0; data_instab = 0; last_req_len = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; mem_rdata = 32'h0;
    idle(3);
    n_checks++;
    if ({tx_start, mem_req, mem_we, rx_overrun} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {tx_start, mem_req, mem_we, rx_overrun});
    end
    n_checks++;
    if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL reset_halt: got %b expected 1", cpu_halt); end
    n_checks++;
    if ({tx_data, mem_addr, mem_wdata} !== 72'h0) begin
      n_fail++; $display("FAIL reset_data: tx_data=%h addr=%h wdata=%h expected 0", tx_data, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    idle(3);
    n_checks++;
    if (cpu_halt !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: halt=%b req=%b expected 1/0", cpu_halt, mem_req);
    end
  endtask

  task automatic test_write();
    bq_t f = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_logs(); ack_delay = 1;
    send_seq(f);
    n_checks++;
    if (mem_req !== 1'b0) begin n_fail++; $display("FAIL write_early_req: got %b expected 0", mem_req); end
    send_byte(8'h33);
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL write_req_latency: got %b expected 1", mem_req); end
    idle(60);
    n_checks++;
    if (req_cnt !== 1 || cap_we !== 1'b1) begin
      n_fail++; $display("FAIL write_req: count=%0d we=%b expected 1/1", req_cnt, cap_we);
    end
    n_checks++;
    if (cap_addr !== 32'h0000_0010 || cap_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL write_bus: addr=%h wdata=%h expected 00000010/deadbeef", cap_addr, cap_wdata);
    end
    n_checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      n_fail++; $display("FAIL write_reply: %0d bytes first=%h expected 1 byte 06", tx_log.size(),
                         (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
    end
  endtask

  task automatic test_read();
    bq_t f = '{8'hA5, 8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h22};
    bq_t exp = '{8'h06, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_logs(); ack_delay = 5; mem_rdata = 32'h1234_5678;
    send_seq(f);
    idle(80);
    n_checks++;
    if (req_cnt !== 1 || last_req_len !== 5 || cap_we !== 1'b0 || cap_addr !== 32'h0000_0020) begin
      n_fail++; $display("FAIL read_bus: count=%0d held=%0d we=%b addr=%h expected 1/5/0/00000020",
                         req_cnt, last_req_len, cap_we, cap_addr);
    end
    n_checks++;
    if (bus_instab !== 0) begin n_fail++; $display("FAIL read_bus_stable: %0d changes expected 0", bus_instab); end
    n_checks++;
    if (tx_log.size() != 5) begin
      n_fail++; $display("FAIL read_reply_len: got %0d expected 5", tx_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (tx_log[i] !== exp[i]) begin
          n_fail++; $display("FAIL read_reply_byte%0d: got %h expected %h", i, tx_log[i], exp[i]);
        end
      end
    end
    n_checks++;
    if (start_viol !== 0 || data_instab !== 0) begin
      n_fail++; $display("FAIL read_tx_handshake: starts_while_busy=%0d data_changes=%0d expected 0/0",
                         start_viol, data_instab);
    end
    ack_delay = 1;
  endtask

  task automatic test_bad_frames();
    clear_logs();
    send_seq('{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00});
    idle(40);
    n_checks++;
    if (req_cnt !== 0 || tx_log.size() != 1 || tx_log[0] !== 8'h15) begin
      n_fail++; $display("FAIL bad_checksum: reqs=%0d bytes=%0d first=%h expected 0/1/15", req_cnt, tx_log.size(),
                         (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
    end
    clear_logs();
    send_seq('{8'hA5, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07});
    idle(40);
    n_checks++;
    if (req_cnt !== 0 || tx_log.size() != 1 || tx_log[0] !== 8'h15) begin
      n_fail++; $display("FAIL bad_cmd: reqs=%0d bytes=%0d first=%h expected 0/1/15", req_cnt, tx_log.size(),
                         (tx_log.size() > 0) ? tx_log[0] : 8'hxx);
    end
  endtask

  task automatic test_gap_below_timeout();
    clear_logs();
    send_seq('{8'hA5, 8'h01, 8'h10, 8'h00});
    idle(45);
    send_seq('{8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33});
    idle(40);
    n_checks++;
    if (req_cnt !== 1 || tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      n_fail++; $display("FAIL gap_no_timeout: reqs=%0d bytes=%0d expected 1 req and reply 06", req_cnt, tx_log.size());
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    send_seq('{8'hA5, 8'h01, 8'h10});
    idle(60);
    n_checks++;
    if (req_cnt !== 0 || tx_log.size() != 0) begin
      n_fail++; $display("FAIL timeout_partial: reqs=%0d bytes=%0d expected 0/0", req_cnt, tx_log.size());
    end
    send_seq('{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33});
    idle(40);
    n_checks++;
    if (req_cnt !== 1 || cap_addr !== 32'h10 || tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      n_fail++; $display("FAIL timeout_recover: reqs=%0d addr=%h bytes=%0d expected 1/00000010/1 (06)",
                         req_cnt, cap_addr, tx_log.size());
    end
  endtask

  task automatic test_run();
    clear_logs();
    send_seq('{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00});
    n_checks++;
    if (cpu_halt !== 1'b1) begin n_fail++; $display("FAIL run_pre_halt: got %b expected 1", cpu_halt); end
    send_byte(8'h03);
    n_checks++;
    if (cpu_halt !== 1'b0) begin n_fail++; $display("FAIL run_halt_drop: got %b expected 0", cpu_halt); end
    idle(30);
    n_checks++;
    if (req_cnt !== 0 || tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
      n_fail++; $display("FAIL run_reply: reqs=%0d bytes=%0d expected 0 reqs and reply 06", req_cnt, tx_log.size());
    end
    clear_logs();
    send_seq('{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33});
    idle(30);
    n_checks++;
    if (cpu_halt !== 1'b0 || req_cnt !== 1 || cap_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL run_then_write: halt=%b reqs=%0d wdata=%h expected 0/1/deadbeef",
                         cpu_halt, req_cnt, cap_wdata);
    end
  endtask

  task automatic test_overrun();
    clear_logs(); ack_delay = 1; mem_rdata = 32'h1234_5678;
    send_seq('{8'hA5, 8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h22});
    n_checks++;
    if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", rx_overrun); end
    idle(6);
    send_byte(8'h55);
    n_checks++;
    if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", rx_overrun); end
    idle(80);
    n_checks++;
    if (rx_overrun !== 1'b1 || tx_log.size() != 5) begin
      n_fail++; $display("FAIL overrun_sticky: flag=%b bytes=%0d expected 1/5", rx_overrun, tx_log.size());
    end
  endtask

  task automatic test_async_reset();
    clear_logs(); ack_delay = 1000;
    send_seq('{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33});
    n_checks++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL areset_pre_req: got %b expected 1", mem_req); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || cpu_halt !== 1'b1 || rx_overrun !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL areset_outputs: req=%b halt=%b overrun=%b addr=%h expected 0/1/0/00000000",
                         mem_req, cpu_halt, rx_overrun, mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 1;
    idle(5);
    n_checks++;
    if (mem_req !== 1'b0 || tx_log.size() != 0) begin
      n_fail++; $display("FAIL areset_quiet: req=%b bytes=%0d expected 0/0", mem_req, tx_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_frames();
    test_gap_below_timeout();
    test_timeout();
    test_run();
    test_overrun();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
